// File: rtl/sa_row_reduce.sv
// Row-wise argmax reducer for the attention output stream.
// Each frame of in_valid-high cycles is cut into NCOL-wide rows; every completed row
// produces {row index, signed max, column of max} into a small result FIFO.
module sa_row_reduce #(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned NCOL       = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   input  logic [63:0] in_data,
   input  logic        out_ready,
   output logic        out_valid,
   output logic [63:0] out_max,
   output logic [2:0]  out_arg,
   output logic [2:0]  out_row,
   output logic        frame_done,
   output logic [3:0]  frame_rows,
   output logic        ovf,
   output logic        err
);

   localparam int unsigned AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [2:0]  LastCol = 3'(NCOL - 1);
   localparam logic [AW:0] CntFull = (AW + 1)'(FIFO_DEPTH);
   localparam logic [AW:0] CntOne  = (AW + 1)'(1);

   typedef enum logic [1:0] {StIdle, StAccum, StDone} state_e;

   state_e             state_q, state_d;
   logic [2:0]         col_q, col_d;
   logic [2:0]         row_q, row_d;
   logic [3:0]         nrows_q, nrows_d;
   logic signed [63:0] max_q, max_d;
   logic [2:0]         arg_q, arg_d;
   logic               ovf_q, ovf_d;
   logic               err_q, err_d;

   logic [63:0]        mem_max [FIFO_DEPTH];
   logic [2:0]         mem_arg [FIFO_DEPTH];
   logic [2:0]         mem_row [FIFO_DEPTH];
   logic [AW-1:0]      wptr_q, wptr_d;
   logic [AW-1:0]      rptr_q, rptr_d;
   logic [AW:0]        cnt_q, cnt_d;

   logic               frame_start, frame_end, row_last;
   logic [2:0]         col_cur, row_cur;
   logic [3:0]         nrows_cur;
   logic signed [63:0] cand_max;
   logic [2:0]         cand_arg;
   logic               full, push, pop;

   // Frame sequencing: ACCUM while data flows, one DONE cycle after the run ends.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle, StDone: state_d = in_valid ? StAccum : StIdle;
         StAccum:        state_d = in_valid ? StAccum : StDone;
         default:        state_d = StIdle;
      endcase
   end

   // Row accumulation, row counting, FIFO bookkeeping and sticky flags.
   always_comb begin
      // A value arriving outside ACCUM opens a new frame, so counters restart with it.
      frame_start = in_valid && (state_q != StAccum);
      frame_end   = !in_valid && (state_q == StAccum);
      col_cur     = frame_start ? 3'd0 : col_q;
      row_cur     = frame_start ? 3'd0 : row_q;
      nrows_cur   = frame_start ? 4'd0 : nrows_q;
      row_last    = in_valid && (col_cur == LastCol);

      // Strict compare so ties keep the earliest column.
      cand_max = max_q;
      cand_arg = arg_q;
      if (col_cur == 3'd0) begin
         cand_max = $signed(in_data);
         cand_arg = 3'd0;
      end else if ($signed(in_data) > max_q) begin
         cand_max = $signed(in_data);
         cand_arg = col_cur;
      end

      col_d   = col_q;
      row_d   = row_q;
      nrows_d = nrows_q;
      max_d   = max_q;
      arg_d   = arg_q;
      ovf_d   = ovf_q;
      err_d   = err_q;

      if (in_valid) begin
         max_d = cand_max;
         arg_d = cand_arg;
         col_d = row_last ? 3'd0 : col_cur + 3'd1;
         if (row_last) begin
            row_d   = row_cur + 3'd1;
            nrows_d = (nrows_cur == 4'd8) ? 4'd8 : nrows_cur + 4'd1;
         end else begin
            row_d   = row_cur;
            nrows_d = nrows_cur;
         end
      end else if (frame_end) begin
         // Partial row is simply forgotten; completed-row count is left for DONE.
         col_d = 3'd0;
         if (col_q != 3'd0) begin
            err_d = 1'b1;
         end
      end

      // A pop in the same cycle frees the slot, so a full FIFO can still accept.
      full = (cnt_q == CntFull);
      pop  = out_valid && out_ready;
      push = row_last && (!full || pop);
      if (row_last && full && !pop) begin
         ovf_d = 1'b1;
      end

      wptr_d = push ? wptr_q + 1'b1 : wptr_q;
      rptr_d = pop ? rptr_q + 1'b1 : rptr_q;
      cnt_d  = cnt_q;
      if (push && !pop) begin
         cnt_d = cnt_q + CntOne;
      end else if (pop && !push) begin
         cnt_d = cnt_q - CntOne;
      end
   end

   // State and counter registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= StIdle;
         col_q   <= 3'd0;
         row_q   <= 3'd0;
         nrows_q <= 4'd0;
         max_q   <= '0;
         arg_q   <= 3'd0;
         ovf_q   <= 1'b0;
         err_q   <= 1'b0;
         wptr_q  <= '0;
         rptr_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         col_q   <= col_d;
         row_q   <= row_d;
         nrows_q <= nrows_d;
         max_q   <= max_d;
         arg_q   <= arg_d;
         ovf_q   <= ovf_d;
         err_q   <= err_d;
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         cnt_q   <= cnt_d;
      end
   end

   // Result storage; contents need no reset because pointers and count do.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_max[wptr_q] <= cand_max;
         mem_arg[wptr_q] <= cand_arg;
         mem_row[wptr_q] <= row_cur;
      end
   end

   // Head entry is zeroed when empty so outputs read 0 after reset.
   always_comb begin
      out_valid  = (cnt_q != '0);
      out_max    = out_valid ? mem_max[rptr_q] : 64'd0;
      out_arg    = out_valid ? mem_arg[rptr_q] : 3'd0;
      out_row    = out_valid ? mem_row[rptr_q] : 3'd0;
      frame_done = (state_q == StDone);
      frame_rows = frame_done ? nrows_q : 4'd0;
      ovf        = ovf_q;
      err        = err_q;
   end

endmodule

// File: doc/sa_row_reduce.md
SA_ROW_REDUCE -- requirements
Module: sa_row_reduce

Interface
REQ-001 Parameter FIFO_DEPTH, default 4: row-result buffer entries, power of two, 2..8.
REQ-002 Parameter NCOL, default 8: values per row, matching the 8-column attention output.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset; synchronous, active-low, sampled on rising clk.
REQ-005 in_valid  input  1  upstream result strobe, driven by the attention stage's out_valid.
REQ-006 in_data  input  64  signed result value, driven by the attention stage's out_data.
REQ-007 out_ready  input  1  downstream accepts current row result.
REQ-008 out_valid  output  1  row result available at FIFO head.
REQ-009 out_max  output  64  signed maximum of the row.
REQ-010 out_arg  output  3  column index of the maximum.
REQ-011 out_row  output  3  row index within the frame.
REQ-012 frame_done  output  1  one-cycle pulse at frame end.
REQ-013 frame_rows  output  4  completed rows in the finished frame; valid while frame_done=1.
REQ-014 ovf  output  1  sticky: a row result was dropped because the FIFO was full.
REQ-015 err  output  1  sticky: a frame ended mid-row.

Function
REQ-016 Input carries no back-pressure; every in_valid=1 cycle SHALL be consumed.
REQ-017 Frame = maximal run of consecutive in_valid=1 cycles, row-major, NCOL values per row, up to 8 rows.
REQ-018 States: IDLE (no frame), ACCUM (in_valid high), DONE (one cycle, frame_done asserted); DONE then IDLE, or ACCUM if in_valid=1.
REQ-019 IDLE/DONE -> ACCUM on in_valid=1; ACCUM -> DONE on in_valid=0.
REQ-020 Column counter col: 0 on each frame start, +1 per accepted value, wraps NCOL-1 -> 0.
REQ-021 At col=0: running max <= in_data, arg <= 0; else if in_data > max (signed, strict): max <= in_data, arg <= col.
REQ-022 Ties keep the lowest column index.
REQ-023 At col=NCOL-1 the row result {row, final max, final arg} (including the current value) SHALL be pushed into the FIFO in the same cycle's update.
REQ-024 Row counter: +1 per pushed-or-dropped row, cleared at frame start; frame_rows = its value during DONE.
REQ-025 Latency: last value of a row in cycle n, FIFO empty -> out_valid=1 with that row in cycle n+1.
REQ-026 out_valid = FIFO non-empty; outputs show head entry; pop when out_valid & out_ready.
REQ-027 Push when full without simultaneous pop: row dropped, ovf <= 1; push when full with pop: both succeed, no ovf.
REQ-028 Frame ending with col != 0: partial row discarded, err <= 1, frame_rows counts complete rows only.
REQ-029 Rows beyond 8 in one frame: row index wraps modulo 8; frame_rows saturates at 8.
REQ-030 A new frame may start in the DONE cycle; frame_done still pulses exactly once for the previous frame.
REQ-031 Head entry and out_valid SHALL remain stable while out_valid=1 and out_ready=0.

Reset
REQ-032 rst_n=0 at a rising edge: state IDLE, counters 0, FIFO empty, out_valid=0, out_max=0, out_arg=0, out_row=0, frame_done=0, frame_rows=0, ovf=0, err=0.
REQ-033 Reset mid-frame discards partial row and FIFO contents; the remaining input run after release is a new frame.
REQ-034 ovf and err clear only on reset.

Verification
REQ-035 Rows {1..8} and {8..1}, out_ready=1 -> row0 max=8 arg=7, row1 max=8 arg=0; frame_done with frame_rows=2.
REQ-036 Row all -5 -> max=-5, arg=0; row {-3,7,7,2,...,0} -> max=7, arg=1 (tie rule).
REQ-037 T=8 frame, out_ready=0 throughout, FIFO_DEPTH=4 -> 4 entries held, rows 4..7 dropped, ovf=1, frame_rows=8.
REQ-038 in_valid high 11 cycles -> one row output, err=1, frame_rows=1.
REQ-039 rst_n=0 for one cycle after 3 values, then full row {0,0,0,9,0,0,0,0} -> row0 max=9 arg=3, err=0.
REQ-040 Two frames separated by one idle cycle -> two frame_done pulses, row index restarts at 0.
